hamm_serial_sched: RTL and testbench
====================================

Name: hamm_serial_sched

Overview:
- Scheduler in front of the serial Hamming(7,4) error-correction datapath, `error_correct_s` (inputs d_in/strobe_in; outputs d_hamm[6:0], d_disp[3:0]).
- Two requesters each present a received 7-bit codeword. The block arbitrates round-robin, shifts the granted codeword into the datapath one bit per strobe, waits for the datapath to settle, then returns the corrected nibble and codeword to the winner with a one-cycle ack.
- Sits between the requester logic and one shared datapath instance.

Parameters:
- HALF_PERIOD, 1, system-clock cycles per strobe phase (low and high); legal range 1..15.
- SETTLE_CYC, 2, cycles after the last strobe before datapath outputs are sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  request per requester; level, held until matching ack.
- cw0  in  7  requester 0 codeword; sampled on grant.
- cw1  in  7  requester 1 codeword; sampled on grant.
- ack  out  2  one-cycle completion pulse per requester.
- rsp_data  out  4  corrected nibble (datapath d_disp), valid with ack.
- rsp_hamm  out  7  corrected codeword (datapath d_hamm), valid with ack.
- busy  out  1  high from grant until the end of the RESP cycle.
- grant_id  out  1  index of the requester being served; holds last value when idle.
- ser_d  out  1  serial bit to datapath d_in.
- ser_strobe  out  1  strobe to datapath strobe_in.
- dp_hamm  in  7  datapath d_hamm.
- dp_disp  in  4  datapath d_disp.

Behaviour:
- Reset (async, immediate): state=IDLE; ack=0, rsp_data=0, rsp_hamm=0, busy=0, grant_id=0, ser_d=0, ser_strobe=0; round-robin pointer points to requester 0.
- All outputs are registered.
- States: IDLE, SHIFT_LO, SHIFT_HI, SETTLE, RESP.
- IDLE, arbitration:
  - If any req is high: grant it. If both are high, grant the requester other than the last one served; the first grant after reset favours requester 0.
  - On grant: latch cw to the internal shift register, set grant_id, set busy=1, set bit_idx=6, go to SHIFT_LO.
- SHIFT_LO: ser_d=cw[bit_idx], ser_strobe=0, held HALF_PERIOD cycles, then go to SHIFT_HI.
- SHIFT_HI: ser_strobe=1, ser_d unchanged, held HALF_PERIOD cycles.
  - bit_idx==0: go to SETTLE.
  - Otherwise: decrement bit_idx, go to SHIFT_LO.
- Shift order and count: bits go MSB first (cw[6] first). Exactly 7 rising edges of ser_strobe per frame. ser_d only changes while ser_strobe is low.
- SETTLE: ser_strobe=0, ser_d=0, held SETTLE_CYC cycles, then go to RESP.
- RESP (one cycle):
  - rsp_data<=dp_disp and rsp_hamm<=dp_hamm, registered on entry to RESP.
  - ack[grant_id]=1 for this cycle only; busy=0 at the end of the cycle; return to IDLE.
  - rsp_data/rsp_hamm hold until the next RESP.
- Latency: grant edge E0, ack high in cycle E0 + 14*HALF_PERIOD + SETTLE_CYC. Defaults give 16 cycles after the grant edge.
- A new grant is possible in the cycle after RESP. Back-to-back frames therefore have one IDLE cycle between them.
- req dropped mid-frame: the frame completes and ack is still pulsed. Requesters may ignore it.
- cw changed mid-frame: no effect, since the latched copy is used.
- req rising during a frame: queued by its level. It is served after the current frame only if still high in IDLE.
- Reset mid-frame: ser_strobe falls at once; no ack is issued; the partial frame is discarded.

Optional Feature:
- Macro: HAMM_ERR_COUNT_EN.
- Defined:
  - Adds output err_cnt[7:0] (reset 0).
  - In RESP, increments when dp_hamm != the latched codeword, i.e. the datapath corrected a bit.
  - Saturates at 255.
- Not defined: no err_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then req=2'b01, cw0=7'b1010101 -> ser_d sequence 1,0,1,0,1,0,1 sampled at 7 ser_strobe rising edges; ack=2'b01 exactly 16 cycles after the grant edge; rsp_data/rsp_hamm equal the datapath model output.
- req=2'b11 held continuously -> grants alternate 0,1,0,1; ack pattern 01,10,01,10; one IDLE cycle between frames.
- rst asserted mid-shift during the 4th bit -> ser_strobe=0 and busy=0 immediately; no ack. After release, a req=2'b10 frame completes normally with grant_id=1.
- HALF_PERIOD=3, SETTLE_CYC=4 -> each strobe phase lasts 3 cycles; ack 46 cycles after grant; still exactly 7 strobes.
- req0 dropped after grant -> frame still runs and ack[0] pulses. cw0 changed mid-frame -> serial bits unchanged.
- HAMM_ERR_COUNT_EN: send cw 7'b1010101 with one bit flipped so the model corrects it -> err_cnt 0→1. Send an error-free cw -> no increment. Force 256 corrections -> err_cnt holds 255.

Source files
------------

// File: rtl/hamm_serial_sched.sv
// Round-robin scheduler feeding one shared serial Hamming(7,4) datapath.
// Optional HAMM_ERR_COUNT_EN adds a saturating corrected-frame counter (err_cnt).
module hamm_serial_sched #(
   parameter int HALF_PERIOD = 1,
   parameter int SETTLE_CYC  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [6:0] cw0,
   input  logic [6:0] cw1,
   input  logic [6:0] dp_hamm,
   input  logic [3:0] dp_disp,
   output logic [1:0] ack,
   output logic [3:0] rsp_data,
   output logic [6:0] rsp_hamm,
   output logic       busy,
   output logic       grant_id,
   output logic       ser_d,
   output logic       ser_strobe
`ifdef HAMM_ERR_COUNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      SETTLE   = 3'd3,
      RESP     = 3'd4
   } state_t;

   localparam logic [3:0] HP_LAST = 4'(HALF_PERIOD - 1);
   localparam logic [3:0] SC_LAST = 4'(SETTLE_CYC - 1);

   state_t     state_r;
   logic [6:0] shreg_r;
   logic [2:0] bit_idx_r;
   logic [3:0] cnt_r;
   logic       last_r;
   logic       pick_s;
   logic [6:0] cw_sel_s;

   // Arbitration: with both requesting, serve the one not served last.
   always_comb begin
      pick_s = 1'b0;
      if (req == 2'b11) begin
         pick_s = ~last_r;
      end else if (req[1]) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // Codeword mux for the requester about to be granted.
   always_comb begin
      cw_sel_s = cw0;
      if (pick_s) begin
         cw_sel_s = cw1;
      end else begin
         cw_sel_s = cw0;
      end
   end

   // Frame sequencer with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         shreg_r    <= 7'd0;
         bit_idx_r  <= 3'd0;
         cnt_r      <= 4'd0;
         last_r     <= 1'b1;
         ack        <= 2'b00;
         rsp_data   <= 4'd0;
         rsp_hamm   <= 7'd0;
         busy       <= 1'b0;
         grant_id   <= 1'b0;
         ser_d      <= 1'b0;
         ser_strobe <= 1'b0;
`ifdef HAMM_ERR_COUNT_EN
         err_cnt    <= 8'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               ack <= 2'b00;
               if (req != 2'b00) begin
                  shreg_r    <= cw_sel_s;
                  grant_id   <= pick_s;
                  last_r     <= pick_s;
                  busy       <= 1'b1;
                  bit_idx_r  <= 3'd6;
                  cnt_r      <= 4'd0;
                  ser_d      <= cw_sel_s[6];
                  ser_strobe <= 1'b0;
                  state_r    <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (cnt_r == HP_LAST) begin
                  cnt_r      <= 4'd0;
                  ser_strobe <= 1'b1;
                  state_r    <= SHIFT_HI;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            SHIFT_HI: begin
               if (cnt_r == HP_LAST) begin
                  cnt_r      <= 4'd0;
                  ser_strobe <= 1'b0;
                  if (bit_idx_r == 3'd0) begin
                     ser_d   <= 1'b0;
                     state_r <= SETTLE;
                  end else begin
                     bit_idx_r <= bit_idx_r - 3'd1;
                     ser_d     <= shreg_r[bit_idx_r - 3'd1];
                     state_r   <= SHIFT_LO;
                  end
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            SETTLE: begin
               if (cnt_r == SC_LAST) begin
                  cnt_r         <= 4'd0;
                  rsp_data      <= dp_disp;
                  rsp_hamm      <= dp_hamm;
                  ack[grant_id] <= 1'b1;
                  state_r       <= RESP;
`ifdef HAMM_ERR_COUNT_EN
                  // A differing codeword means the datapath flipped a bit.
                  if ((dp_hamm != shreg_r) && (err_cnt != 8'hFF)) begin
                     err_cnt <= err_cnt + 8'd1;
                  end
`endif
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            RESP: begin
               ack     <= 2'b00;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               ack        <= 2'b00;
               busy       <= 1'b0;
               ser_d      <= 1'b0;
               ser_strobe <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamm_serial_sched.sv
// Directed bench for hamm_serial_sched with a bit-serial Hamming datapath model
// and a scoreboard of expected responses per frame.
module tb_hamm_serial_sched;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] req_a, req_b;
   logic [6:0] cw0_v, cw1_v;
   logic sel;

   logic [1:0] ack_a, ack_b;
   logic [3:0] rsp_data_a, rsp_data_b, dpd_a, dpd_b;
   logic [6:0] rsp_hamm_a, rsp_hamm_b, dph_a, dph_b;
   logic busy_a, busy_b, gid_a, gid_b, sd_a, sd_b, ss_a, ss_b;
`ifdef HAMM_ERR_COUNT_EN
   logic [7:0] err_a, err_b;
   int exp_err;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   function automatic logic [6:0] fix7(input logic [6:0] c);
      logic [2:0] s;
      logic [6:0] r;
      r = c;
      s = 3'd0;
      for (int p = 1; p <= 7; p++) begin
         if (c[p-1]) s = s ^ 3'(p);
      end
      if (s != 3'd0) r[s - 3'd1] = ~r[s - 3'd1];
      return r;
   endfunction

   function automatic logic [3:0] nib(input logic [6:0] c);
      return {c[6], c[5], c[4], c[2]};
   endfunction

   // datapath models: shift on strobe rise, combinational correction
   logic [6:0] sr_a = 7'd0;
   logic [6:0] sr_b = 7'd0;
   always @(posedge ss_a) sr_a <= {sr_a[5:0], sd_a};
   always @(posedge ss_b) sr_b <= {sr_b[5:0], sd_b};
   assign dph_a = fix7(sr_a);
   assign dpd_a = nib(fix7(sr_a));
   assign dph_b = fix7(sr_b);
   assign dpd_b = nib(fix7(sr_b));

   hamm_serial_sched u_a (
      .clk(clk), .rst(rst), .req(req_a), .cw0(cw0_v), .cw1(cw1_v),
      .dp_hamm(dph_a), .dp_disp(dpd_a), .ack(ack_a), .rsp_data(rsp_data_a),
      .rsp_hamm(rsp_hamm_a), .busy(busy_a), .grant_id(gid_a), .ser_d(sd_a),
      .ser_strobe(ss_a)
`ifdef HAMM_ERR_COUNT_EN
      , .err_cnt(err_a)
`endif
   );

   hamm_serial_sched #(.HALF_PERIOD(3), .SETTLE_CYC(4)) u_b (
      .clk(clk), .rst(rst), .req(req_b), .cw0(cw0_v), .cw1(cw1_v),
      .dp_hamm(dph_b), .dp_disp(dpd_b), .ack(ack_b), .rsp_data(rsp_data_b),
      .rsp_hamm(rsp_hamm_b), .busy(busy_b), .grant_id(gid_b), .ser_d(sd_b),
      .ser_strobe(ss_b)
`ifdef HAMM_ERR_COUNT_EN
      , .err_cnt(err_b)
`endif
   );

   wire [1:0] ack_s      = sel ? ack_b : ack_a;
   wire [3:0] rsp_data_s = sel ? rsp_data_b : rsp_data_a;
   wire [6:0] rsp_hamm_s = sel ? rsp_hamm_b : rsp_hamm_a;
   wire       busy_s     = sel ? busy_b : busy_a;
   wire       gid_s      = sel ? gid_b : gid_a;
   wire       sd_s       = sel ? sd_b : sd_a;
   wire       ss_s       = sel ? ss_b : ss_a;

   logic [6:0] bits_seen = 7'd0;
   int nbits = 0;
   always @(posedge ss_s) begin
      bits_seen = {bits_seen[5:0], sd_s};
      nbits = nbits + 1;
   end

   typedef struct packed {
      logic       id;
      logic [6:0] cw;
      logic [6:0] hamm;
      logic [3:0] data;
   } exp_t;
   exp_t sb[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic id, input logic [6:0] c);
      exp_t e;
      e.id = id;
      e.cw = c;
      e.hamm = fix7(c);
      e.data = nib(fix7(c));
      sb.push_back(e);
`ifdef HAMM_ERR_COUNT_EN
      if (fix7(c) != c && exp_err < 255) exp_err++;
`endif
   endtask

   task automatic wait_frame(input int lat, input int hp, input logic [1:0] next_req,
                             input bit gap_chk, input bit mutate);
      int n;
      int hi;
      exp_t e;
      n = 0;
      while (!busy_s && n < 20) begin
         tick();
         n++;
      end
      check("grant_seen", 32'(busy_s), 32'd1);
      if (!busy_s) return;
      if (gap_chk) check("idle_gap", 32'(n), 32'd1);
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check("grant_id", 32'(gid_s), 32'(e.id));
      nbits = 0;
      hi = 0;
      n = 0;
      while (ack_s == 2'b00 && n < 200) begin
         tick();
         n++;
         if (ss_s) hi++;
         if (mutate && n == 3) begin
            req_a = 2'b00;
            cw0_v = ~cw0_v;
         end
      end
      if (sel) req_b = next_req;
      else req_a = next_req;
      check("latency", 32'(n), 32'(lat));
      check("ack", 32'(ack_s), e.id ? 32'd2 : 32'd1);
      check("rsp_hamm", 32'(rsp_hamm_s), 32'(e.hamm));
      check("rsp_data", 32'(rsp_data_s), 32'(e.data));
      check("strobe_cnt", 32'(nbits), 32'd7);
      check("ser_bits", 32'(bits_seen), 32'(e.cw));
      check("strobe_hi_cycles", 32'(hi), 32'(7 * hp));
      tick();
      check("ack_clear", 32'(ack_s), 32'd0);
      check("busy_clear", 32'(busy_s), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
`ifdef HAMM_ERR_COUNT_EN
      exp_err = 0;
`endif
   endtask

   initial begin
      int n;
      rst = 1'b1;
      req_a = 2'b00;
      req_b = 2'b00;
      cw0_v = 7'd0;
      cw1_v = 7'd0;
      sel = 1'b0;
`ifdef HAMM_ERR_COUNT_EN
      exp_err = 0;
`endif
      tick();
      check("rst_ack", 32'(ack_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_gid", 32'(gid_a), 32'd0);
      check("rst_ser_d", 32'(sd_a), 32'd0);
      check("rst_strobe", 32'(ss_a), 32'd0);
      check("rst_rsp_data", 32'(rsp_data_a), 32'd0);
      check("rst_rsp_hamm", 32'(rsp_hamm_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // single frame from requester 0
      cw0_v = 7'b1010101;
      push(1'b0, cw0_v);
      req_a = 2'b01;
      wait_frame(16, 1, 2'b00, 1'b0, 1'b0);

      // both requesting: alternate 0,1,0,1
      do_reset();
      cw0_v = 7'b1010100;
      cw1_v = 7'b0110011;
      push(1'b0, cw0_v);
      push(1'b1, cw1_v);
      push(1'b0, cw0_v);
      push(1'b1, cw1_v);
      req_a = 2'b11;
      wait_frame(16, 1, 2'b11, 1'b0, 1'b0);
      wait_frame(16, 1, 2'b11, 1'b1, 1'b0);
      wait_frame(16, 1, 2'b11, 1'b1, 1'b0);
      wait_frame(16, 1, 2'b00, 1'b1, 1'b0);

      // reset during the 4th bit, then a clean frame from requester 1
      tick();
      cw0_v = 7'b0001111;
      req_a = 2'b01;
      n = 0;
      while (!busy_a && n < 20) begin
         tick();
         n++;
      end
      check("mid_grant", 32'(busy_a), 32'd1);
      repeat (7) tick();
      check("mid_strobe_high", 32'(ss_a), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_strobe", 32'(ss_a), 32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      check("mid_rst_ack", 32'(ack_a), 32'd0);
      req_a = 2'b10;
      cw1_v = 7'b1100110;
      tick();
      @(negedge clk);
      rst = 1'b0;
`ifdef HAMM_ERR_COUNT_EN
      exp_err = 0;
`endif
      push(1'b1, cw1_v);
      wait_frame(16, 1, 2'b00, 1'b0, 1'b0);

      // req0 dropped and cw0 altered mid-frame
      tick();
      cw0_v = 7'b1011010;
      push(1'b0, cw0_v);
      req_a = 2'b01;
      wait_frame(16, 1, 2'b00, 1'b0, 1'b1);

      // slow instance: HALF_PERIOD=3, SETTLE_CYC=4
      sel = 1'b1;
      tick();
      cw1_v = 7'b0011001;
      push(1'b1, cw1_v);
      req_b = 2'b10;
      wait_frame(46, 3, 2'b00, 1'b0, 1'b0);
      sel = 1'b0;

`ifdef HAMM_ERR_COUNT_EN
      do_reset();
      check("err_rst", 32'(err_a), 32'd0);
      cw0_v = 7'b1010100;
      push(1'b0, cw0_v);
      req_a = 2'b01;
      wait_frame(16, 1, 2'b00, 1'b0, 1'b0);
      check("err_one", 32'(err_a), 32'd1);
      tick();
      cw0_v = 7'b1010101;
      push(1'b0, cw0_v);
      req_a = 2'b01;
      wait_frame(16, 1, 2'b00, 1'b0, 1'b0);
      check("err_clean", 32'(err_a), 32'd1);
      tick();
      cw0_v = 7'b0010101;
      req_a = 2'b01;
      for (int i = 0; i < 256; i++) begin
         push(1'b0, cw0_v);
         wait_frame(16, 1, (i == 255) ? 2'b00 : 2'b01, 1'b0, 1'b0);
      end
      check("err_sat", 32'(err_a), 32'(exp_err));
      check("err_sat_255", 32'(err_a), 32'd255);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
